// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding
// and the cycle-counter width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_fulladdr.sv
// Existing 1-bit full-adder cell used as the serial datapath of serial_add_ctrl.
module fulladdr (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fulladdr cell stepped over WIDTH cycles.
// Optional macro SERIAL_ADD_OVF_EN adds the two's-complement overflow output ovf.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADD_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_sh_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic             w_accept;
    logic             w_step;
    logic             w_finish;

    fulladdr u_fa (w_s, w_c, r_sh_a[0], r_sh_b[0], r_carry);

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_sh_s  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_sh_a  <= a_in;
            r_sh_b  <= b_in;
            r_sh_s  <= '0;
            r_carry <= cin_in;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
            r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
            r_sh_s  <= {w_s, r_sh_s[WIDTH-1:1]};
            r_carry <= w_c;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Result is loaded on the edge entering DONE so sum_out/cout are valid while done is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            r_done <= w_finish;
            if (w_finish) begin
                r_sum  <= {w_s, r_sh_s[WIDTH-1:1]};
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // r_carry during the last step is the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_finish) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign ovf = r_ovf;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign sum_out = r_sum;
    assign cout    = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed, scoreboard-based bench for serial_add_ctrl at WIDTH=8 and WIDTH=3.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       rst3, start3, cin3, busy3, done3, cout3;
    logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf8, ovf3;
    logic       qo8[$];
`endif

    logic [8:0] q8[$];
    logic [3:0] q3[$];

    int n_assert = 0;
    int n_fail   = 0;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout8), .ovf(ovf8)
`else
        .cout(cout8)
`endif
    );

    serial_add_ctrl #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3), .a_in(a3), .b_in(b3), .cin_in(cin3),
        .busy(busy3), .done(done3), .sum_out(sum3),
`ifdef SERIAL_ADD_OVF_EN
        .cout(cout3), .ovf(ovf3)
`else
        .cout(cout3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one start pulse on the 8-bit instance; returns at the first negedge after accept.
    task automatic start8_op(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] e;
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        q8.push_back(e);
`ifdef SERIAL_ADD_OVF_EN
        qo8.push_back((a[7] == b[7]) && (e[7] != a[7]));
`endif
        @(negedge clk);
        start8 = 1'b0;
        check("busy8_after_accept", {31'd0, busy8}, 32'd1);
    endtask

    task automatic finish8(input int lat0);
        int lat;
        logic [8:0] e;
        lat = lat0;
        while (!done8 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check("latency8", lat, 32'd9);
        e = (q8.size() > 0) ? q8.pop_front() : 9'h1FF;
        check("result8", {23'd0, cout8, sum8}, {23'd0, e});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf8", {31'd0, ovf8}, {31'd0, (qo8.size() > 0) ? qo8.pop_front() : 1'bx});
`endif
        @(negedge clk);
        check("done8_one_cycle", {31'd0, done8}, 32'd0);
        check("busy8_idle", {31'd0, busy8}, 32'd0);
        check("sum8_hold", {23'd0, cout8, sum8}, {23'd0, e});
    endtask

    initial begin
        int         n;
        logic       saw_done;
        logic [6:0] idx;
        logic [3:0] e3;

        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        rst3 = 1'b1; start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset8", {20'd0, busy8, done8, cout8, sum8}, 32'd0);
        check("reset3", {25'd0, busy3, done3, cout3, sum3}, 32'd0);
        rst8 = 1'b0; rst3 = 1'b0;

        start8_op(8'h00, 8'h00, 1'b0);
        finish8(1);
        start8_op(8'hFF, 8'h01, 1'b0);
        finish8(1);
        start8_op(8'h7F, 8'h01, 1'b0);
        finish8(1);

        // Start while busy must be ignored.
        start8_op(8'hA5, 8'h3C, 1'b1);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        finish8(4);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done = saw_done | done8;
        end
        check("no_extra_done8", {31'd0, saw_done}, 32'd0);
        check("hold_E2", {23'd0, cout8, sum8}, 32'h0E2);

        // Asynchronous reset mid-RUN.
        start8_op(8'h55, 8'hAA, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b1;
        #1;
        check("rst_async8", {20'd0, busy8, done8, cout8, sum8}, 32'd0);
        q8.delete();
`ifdef SERIAL_ADD_OVF_EN
        qo8.delete();
`endif
        @(negedge clk);
        rst8 = 1'b0;
        saw_done = 1'b0;
        repeat (14) begin
            @(negedge clk);
            saw_done = saw_done | done8;
        end
        check("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        start8_op(8'h12, 8'h34, 1'b0);
        finish8(1);

        // WIDTH=3 exhaustive with start held high.
        @(negedge clk);
        idx = 7'd0;
        a3 = idx[5:3]; b3 = idx[2:0]; cin3 = idx[6]; start3 = 1'b1;
        q3.push_back({1'b0, idx[5:3]} + {1'b0, idx[2:0]} + {3'd0, idx[6]});
        for (int i = 0; i < 128; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done3 && n < 12);
            check((i == 0) ? "latency3" : "spacing3", n, (i == 0) ? 32'd4 : 32'd5);
            e3 = (q3.size() > 0) ? q3.pop_front() : 4'hF;
            check("result3", {28'd0, cout3, sum3}, {28'd0, e3});
            if (i < 127) begin
                idx = 7'(i + 1);
                a3 = idx[5:3]; b3 = idx[2:0]; cin3 = idx[6];
                q3.push_back({1'b0, idx[5:3]} + {1'b0, idx[2:0]} + {3'd0, idx[6]});
            end else begin
                start3 = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        check("busy3_end", {31'd0, busy3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
